// File: rtl/text_capture.sv
// Captures bytes written to the ACIA transmit register into a buffer
// and serves them back to the HPS through the ioctl upload path.
module text_capture #(
  parameter int         ADDR_W   = 13,
  parameter bit         FILTER   = 1'b1,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              tx_strobe,
  input  logic [7:0]        tx_data,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W:0]   capture_count,
  output logic              overflow,
  output logic              capturing
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    UPLOAD
  } state_t;

  state_t state_q, state_d;

  logic            en_q;
  logic            pend_q, pend_d, pend_c;
  logic            rise, acc, full, we;
  logic            ovf_d;
  logic [ADDR_W:0] cnt_d;
  logic            rd_seen_q, rd_hit_q;
  logic [7:0]      ram_q;
  logic [7:0]      mem [DEPTH];

  assign acc    = !FILTER || (tx_data != 8'h00 && tx_data != 8'h7f);
  // count saturates at DEPTH, so the top bit alone marks a full buffer
  assign full   = capture_count[ADDR_W];
  assign rise   = capture_en & ~en_q;
  assign pend_c = (pend_q | rise) & capture_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = capture_count;
    ovf_d   = overflow;
    pend_d  = pend_c;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ioctl_upload) begin
          state_d = UPLOAD;
        end else if (pend_c) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (tx_strobe && acc) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            we    = 1'b1;
            cnt_d = capture_count + {{ADDR_W{1'b0}}, 1'b1};
          end
        end
        if (ioctl_upload)    state_d = UPLOAD;
        else if (!capture_en) state_d = IDLE;
      end
      UPLOAD: begin
        if (tx_strobe && acc) ovf_d = 1'b1;
        if (!ioctl_upload) begin
          if (capture_en) begin
            state_d = CAPTURE;
            // an arm deferred by the upload is honoured now
            if (pend_c) begin
              cnt_d  = '0;
              ovf_d  = 1'b0;
              pend_d = 1'b0;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    en_q <= capture_en;
    if (reset) begin
      state_q       <= IDLE;
      capture_count <= '0;
      overflow      <= 1'b0;
      capturing     <= 1'b0;
      pend_q        <= 1'b0;
      rd_seen_q     <= 1'b0;
      rd_hit_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      capture_count <= cnt_d;
      overflow      <= ovf_d;
      capturing     <= (state_d == CAPTURE);
      pend_q        <= pend_d;
      if (ioctl_rd) begin
        rd_seen_q <= 1'b1;
        rd_hit_q  <= ({1'b0, ioctl_addr} < capture_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) mem[capture_count[ADDR_W-1:0]] <= tx_data;
    if (ioctl_rd)     ram_q <= mem[ioctl_addr];
  end

  assign ioctl_din = !rd_seen_q ? 8'h00 :
                     rd_hit_q   ? ram_q : PAD_BYTE;

endmodule
